rr_grant_arb: RTL

//  Registered N-way request arbiter; successor to the combinational priority-selector tree.

---
 rtl/arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 42 ++++
 rtl/rr_grant_arb.sv | 105 ++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and constant helpers for the round-robin grant arbiter.
package arb_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   // Ceiling log2 usable in parameter expressions; clog2(1) == 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-start picker: highest index at or below start wins,
// wrapping from 0 back to NUM_REQ-1.
module rr_pick
   import arb_pkg::*;
#(
   parameter  int NUM_REQ = 8,
   localparam int IDX_W   = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   start,
   output logic [NUM_REQ-1:0] win,
   output logic [IDX_W-1:0]   win_idx,
   output logic               found
);

   logic [NUM_REQ-1:0] rotated;
   logic [IDX_W-1:0]   src_idx [NUM_REQ];
   logic [IDX_W-1:0]   rot_idx;
   logic               rot_found;

   // Rotate so that bit 'start' lands on the top position; index math wraps mod NUM_REQ.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign src_idx[gi] = IDX_W'(gi) + start + IDX_W'(1);
      assign rotated[gi] = req[src_idx[gi]];
   end

   always_comb begin
      rot_found = 1'b0;
      rot_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rotated[i]) begin
            rot_found = 1'b1;
            rot_idx   = IDX_W'(i);
         end
      end
   end

   assign found   = rot_found;
   assign win_idx = rot_found ? (rot_idx + start + IDX_W'(1)) : '0;
   assign win     = rot_found ? (NUM_REQ'(1) << win_idx) : '0;

endmodule

// File: rtl/rr_grant_arb.sv
// Registered N-way arbiter with fixed or round-robin priority, grant hold,
// and hold-limit preemption when other requesters are waiting.
module rr_grant_arb
   import arb_pkg::*;
#(
   parameter  int NUM_REQ  = 8,
   parameter  int MAX_HOLD = 16,
   localparam int IDX_W    = clog2(NUM_REQ)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               en,
   input  logic               rr_mode,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_valid,
   output logic               req_up
);

   localparam int HOLD_W = (clog2(MAX_HOLD) < 1) ? 1 : clog2(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

   arb_state_t         state_reg;
   logic [IDX_W-1:0]   ptr_reg;
   logic [HOLD_W-1:0]  hold_cnt_reg;
   logic [NUM_REQ-1:0] gnt_reg;
   logic [IDX_W-1:0]   gnt_idx_reg;

   logic [NUM_REQ-1:0] pick_req;
   logic [IDX_W-1:0]   pick_start;
   logic [NUM_REQ-1:0] pick_win;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_found;
   logic               owner_req;
   logic               hold_limit;

   // The current owner is masked out, so any pick is a different requester.
   assign pick_req   = req & ~gnt_reg;
   assign pick_start = rr_mode ? ptr_reg : IDX_W'(NUM_REQ - 1);
   assign owner_req  = |(req & gnt_reg);
   assign hold_limit = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LAST);

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req     (pick_req),
      .start   (pick_start),
      .win     (pick_win),
      .win_idx (pick_idx),
      .found   (pick_found)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= ARB_IDLE;
         ptr_reg      <= IDX_W'(NUM_REQ - 1);
         hold_cnt_reg <= '0;
         gnt_reg      <= '0;
         gnt_idx_reg  <= '0;
      end else begin
         case (state_reg)
            ARB_IDLE: begin
               if (en && pick_found) begin
                  state_reg    <= ARB_GRANT;
                  gnt_reg      <= pick_win;
                  gnt_idx_reg  <= pick_idx;
                  hold_cnt_reg <= '0;
                  if (rr_mode) begin
                     ptr_reg <= pick_idx - IDX_W'(1);
                  end
               end
            end
            ARB_GRANT: begin
               if (!en || (!owner_req && !pick_found)) begin
                  state_reg    <= ARB_IDLE;
                  gnt_reg      <= '0;
                  gnt_idx_reg  <= '0;
                  hold_cnt_reg <= '0;
               end else if (!owner_req || (hold_limit && pick_found)) begin
                  // Hand over directly to the next winner, no idle bubble.
                  gnt_reg      <= pick_win;
                  gnt_idx_reg  <= pick_idx;
                  hold_cnt_reg <= '0;
                  if (rr_mode) begin
                     ptr_reg <= pick_idx - IDX_W'(1);
                  end
               end else if (hold_cnt_reg != HOLD_LAST) begin
                  hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
               end
            end
            default: begin
               state_reg <= ARB_IDLE;
               gnt_reg   <= '0;
            end
         endcase
      end
   end

   assign gnt       = gnt_reg;
   assign gnt_idx   = gnt_idx_reg;
   assign gnt_valid = |gnt_reg;
   assign req_up    = |req;

endmodule
